// File: rtl/keypress_gen_if.sv
// Button-press request/response bundle: requester drives start/amount,
// the generator returns the active-low button drive and sequence status.
interface keypress_gen_if;
    logic       start;
    logic [9:0] amount;
    logic [3:0] button;
    logic       busy;
    logic       done;
    logic [7:0] press_count;

    modport master (
        output start, amount,
        input  button, busy, done, press_count
    );

    modport slave (
        input  start, amount,
        output button, busy, done, press_count
    );
endinterface

// File: rtl/keypress_gen.sv
// Emits 'amount' as greedy active-low presses of weighted buttons (8/4/2/1); optional KEYPRESS_GEN_BOUNCE_EN adds a bounce.
// Latency: button falls 2 cycles after accept; each press period (HOLD+GAP)*TICK_LIMIT+1 cycles (+2 ticks with bounce).
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
module keypress_gen #(
    parameter int TICK_LIMIT = 125000,
    parameter int HOLD_TICKS = 4,
    parameter int GAP_TICKS  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    keypress_gen_if.slave  bus
);

    localparam int PW = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
    localparam int TW = 16;
`ifdef KEYPRESS_GEN_BOUNCE_EN
    localparam int PRESS_TICKS = HOLD_TICKS + 2;
`else
    localparam int PRESS_TICKS = HOLD_TICKS;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PRESS,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [9:0]    r_remaining;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_tick;
    logic [3:0]    r_wt;
    logic [3:0]    r_button;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    r_press_count;

    logic          w_tick_end;
    logic [3:0]    w_wt;

    assign w_tick_end = (r_presc == PW'(TICK_LIMIT - 1));

    // Weights are one-hot, so the inverted weight is directly the button drive.
    always_comb begin
        w_wt = 4'd1;
        if (r_remaining >= 10'd8)
            w_wt = 4'd8;
        else if (r_remaining >= 10'd4)
            w_wt = 4'd4;
        else if (r_remaining >= 10'd2)
            w_wt = 4'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_presc       <= '0;
            r_tick        <= '0;
            r_wt          <= '0;
            r_button      <= 4'b1111;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_remaining   <= bus.amount;
                        r_press_count <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (r_remaining == 10'd0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wt     <= w_wt;
                        r_button <= ~w_wt;
                        r_presc  <= '0;
                        r_tick   <= '0;
                        r_state  <= S_PRESS;
                    end
                end
                S_PRESS: begin
                    if (w_tick_end) begin
                        r_presc <= '0;
                        if (r_tick == TW'(PRESS_TICKS - 1)) begin
                            r_tick        <= '0;
                            r_button      <= 4'b1111;
                            r_remaining   <= r_remaining - {6'd0, r_wt};
                            r_press_count <= r_press_count + 8'd1;
                            r_state       <= S_RELEASE;
                        end else begin
                            r_tick <= r_tick + TW'(1);
`ifdef KEYPRESS_GEN_BOUNCE_EN
                            // Tick 0 low, tick 1 bounced high, then the real hold.
                            if (r_tick == TW'(0))
                                r_button <= 4'b1111;
                            else if (r_tick == TW'(1))
                                r_button <= ~r_wt;
`endif
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                S_RELEASE: begin
                    if (w_tick_end) begin
                        r_presc <= '0;
                        if (r_tick == TW'(GAP_TICKS - 1)) begin
                            r_tick  <= '0;
                            r_state <= S_SELECT;
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_button <= 4'b1111;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.button      = r_button;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.press_count = r_press_count;

endmodule
